// File: rtl/tri_bus_pkg.sv
// tri_bus_pkg: shared types and constants for the three-state data bus controller.
package tri_bus_pkg;
   typedef enum logic [1:0] {IDLE, XFER, TURN} state_t;
   localparam int BUS_W = 32;
   localparam logic DIR_WR = 1'b1;
   localparam logic DIR_RD = 1'b0;
endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req scanning upward from ptr with wrap.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         pick,
   output logic [$clog2(N)-1:0] idx,
   output logic                 valid
);
   localparam int IW = $clog2(N);
   int k;
   always_comb begin
      k = 0;
      idx = '0;
      valid = 1'b0;
      // scan farthest offset first so the nearest requester overwrites it
      for (int o = N - 1; o >= 0; o--) begin
         k = (int'(ptr) + o) % N;
         if (req[k[IW-1:0]]) begin
            idx = k[IW-1:0];
            valid = 1'b1;
         end
      end
      pick = valid ? N'(1) << idx : '0;
   end
endmodule

// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter: round-robin owner sequencing and registered enables for the shared bus,
// with a forced idle turnaround between every grant so the bus is never contended.
module tri_bus_arbiter
   import tri_bus_pkg::*;
#(
   parameter int N          = 4,
   parameter int MAX_BURST  = 8,
   parameter int TURNAROUND = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         wr,
   input  logic [N-1:0]         last,
   output logic [N-1:0]         gnt,
   output logic [N-1:0]         snd_en,
   output logic [N-1:0]         rcv_en,
   output logic                 mem_snd_en,
   output logic                 mem_rcv_en,
   output logic                 busy,
   output logic [$clog2(N)-1:0] owner
);
   localparam int IW = $clog2(N);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam int TW = $clog2(TURNAROUND + 1);
   state_t          state;
   logic [IW-1:0]   ptr;
   logic [CW-1:0]   beats;
   logic [TW-1:0]   tcnt;
   logic [N-1:0]    pick;
   logic [IW-1:0]   pidx;
   logic            pvalid;
   logic            pwr;
   logic            done;
   rr_pick #(.N(N)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .pick  (pick),
      .idx   (pidx),
      .valid (pvalid)
   );
   assign pwr  = wr[pidx] == DIR_WR;
   // beats holds completed beats before this one, so MAX_BURST-1 marks the final allowed beat
   assign done = last[owner] | ~req[owner] | (beats == CW'(MAX_BURST - 1));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         beats      <= '0;
         tcnt       <= '0;
         gnt        <= '0;
         snd_en     <= '0;
         rcv_en     <= '0;
         mem_snd_en <= 1'b0;
         mem_rcv_en <= 1'b0;
         busy       <= 1'b0;
         owner      <= '0;
      end else begin
         case (state)
            IDLE: if (pvalid) begin
               state      <= XFER;
               gnt        <= pick;
               owner      <= pidx;
               ptr        <= (pidx == IW'(N - 1)) ? '0 : pidx + 1'b1;
               snd_en     <= pwr ? pick : '0;
               rcv_en     <= pwr ? '0 : pick;
               mem_snd_en <= ~pwr;
               mem_rcv_en <= pwr;
               busy       <= 1'b1;
               beats      <= '0;
            end
            XFER: begin
               beats <= (beats == CW'(MAX_BURST)) ? beats : beats + 1'b1;
               if (done) begin
                  state      <= TURN;
                  tcnt       <= '0;
                  gnt        <= '0;
                  snd_en     <= '0;
                  rcv_en     <= '0;
                  mem_snd_en <= 1'b0;
                  mem_rcv_en <= 1'b0;
               end
            end
            TURN: begin
               beats <= '0;
               tcnt  <= tcnt + 1'b1;
               if (tcnt == TW'(TURNAROUND - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb_tri_bus_arbiter: directed scoreboard bench; each step queues the outputs expected after the next edge.
module tb_tri_bus_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, wr, last;
   logic [3:0] gnt, snd_en, rcv_en;
   logic       mem_snd_en, mem_rcv_en, busy;
   logic [1:0] owner;

   typedef struct packed {
      logic [3:0] gnt, snd, rcv;
      logic       msnd, mrcv, busy;
      logic [1:0] owner;
   } obs_t;

   obs_t  exp_q[$];
   string tag_q[$];
   int    total = 0;
   int    passed = 0;

   tri_bus_arbiter #(.N(4), .MAX_BURST(8), .TURNAROUND(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .wr         (wr),
      .last       (last),
      .gnt        (gnt),
      .snd_en     (snd_en),
      .rcv_en     (rcv_en),
      .mem_snd_en (mem_snd_en),
      .mem_rcv_en (mem_rcv_en),
      .busy       (busy),
      .owner      (owner)
   );

   always #5 clk = ~clk;

   function automatic obs_t cur();
      obs_t o;
      o.gnt = gnt; o.snd = snd_en; o.rcv = rcv_en;
      o.msnd = mem_snd_en; o.mrcv = mem_rcv_en; o.busy = busy; o.owner = owner;
      return o;
   endfunction

   function automatic obs_t xf(int i, logic w);
      obs_t e;
      e.gnt = 4'b1 << i;
      e.snd = w ? e.gnt : 4'b0;
      e.rcv = w ? 4'b0 : e.gnt;
      e.msnd = ~w; e.mrcv = w; e.busy = 1'b1; e.owner = 2'(i);
      return e;
   endfunction

   function automatic obs_t lo(int i, logic b);
      obs_t e;
      e = '0;
      e.busy = b; e.owner = 2'(i);
      return e;
   endfunction

   task automatic check(string tag, obs_t o, obs_t e);
      total++;
      assert (o === e) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, o, e);
   endtask

   task automatic drain();
      @(negedge clk);
      if (exp_q.size() > 0) check(tag_q.pop_front(), cur(), exp_q.pop_front());
      total++;
      assert ($countones(snd_en) + int'(mem_snd_en) <= 1 && $countones(gnt) <= 1) passed++;
      else $error("FAIL invariant observed snd=%b mem_snd=%b gnt=%b expected one driver at most", snd_en, mem_snd_en, gnt);
   endtask

   task automatic step(string tag, logic [3:0] r, logic [3:0] w, logic [3:0] l, obs_t e);
      drain();
      req = r; wr = w; last = l;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // mode 0: last on beat len, 1: no last (MAX_BURST cut), 2: owner drops req on beat len
   task automatic burst(string tag, int o, logic [3:0] r, logic [3:0] w, int len, int mode);
      logic [3:0] m;
      logic       wo;
      m = 4'b1 << o;
      wo = |(w & m);
      step({tag, "_grant"}, r, w, 4'b0, xf(o, wo));
      for (int k = 2; k <= len; k++) step({tag, "_beat"}, r, w ^ m, 4'b0, xf(o, wo));
      if (mode == 0) step({tag, "_exit"}, r, w ^ m, m, lo(o, 1'b1));
      else if (mode == 1) step({tag, "_exit"}, r, w ^ m, 4'b0, lo(o, 1'b1));
      else step({tag, "_exit"}, r & ~m, w, 4'b0, lo(o, 1'b1));
   endtask

   initial begin
      rst = 1'b1; req = '0; wr = '0; last = '0;
      @(negedge clk);
      @(negedge clk);
      check("reset", cur(), lo(0, 1'b0));
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         burst("rr", i % 4, 4'hF, 4'b0101, 1, 0);
         step("rr_turn", (i == 4) ? 4'h0 : 4'hF, 4'b0101, 4'b0, lo(i % 4, 1'b0));
      end
      burst("wr0", 0, 4'b0001, 4'b0001, 3, 0);
      step("wr0_turn", 4'b0, 4'b0, 4'b0, lo(0, 1'b0));
      step("wr0_idle", 4'b0, 4'b0, 4'b0, lo(0, 1'b0));
      burst("dir_w", 1, 4'b0010, 4'b0010, 2, 0);
      step("dir_turn", 4'b0010, 4'b0000, 4'b0, lo(1, 1'b0));
      burst("dir_r", 1, 4'b0010, 4'b0000, 3, 0);
      step("dir_r_turn", 4'b1100, 4'b0000, 4'b0, lo(1, 1'b0));
      burst("max", 2, 4'b1100, 4'b0000, 8, 1);
      step("max_turn", 4'b1000, 4'b1000, 4'b0, lo(2, 1'b0));
      burst("drop", 3, 4'b1000, 4'b1000, 2, 2);
      step("drop_turn", 4'b1010, 4'b0000, 4'b0, lo(3, 1'b0));
      burst("ptr0", 1, 4'b1010, 4'b0000, 1, 0);
      step("ptr0_turn", 4'b0010, 4'b0010, 4'b0, lo(1, 1'b0));
      step("rst_b1", 4'b0010, 4'b0010, 4'b0, xf(1, 1'b1));
      step("rst_b2", 4'b0010, 4'b0010, 4'b0, xf(1, 1'b1));
      step("rst_b3", 4'b0010, 4'b0010, 4'b0, xf(1, 1'b1));
      drain();
      rst = 1'b1;
      #1;
      check("rst_async", cur(), lo(0, 1'b0));
      req = 4'b0;
      @(negedge clk);
      check("rst_hold", cur(), lo(0, 1'b0));
      rst = 1'b0;
      burst("rst_r2", 2, 4'b0100, 4'b0100, 2, 0);
      step("rst_r2_turn", 4'b0, 4'b0, 4'b0, lo(2, 1'b0));
      step("rst_r2_idle", 4'b0, 4'b0, 4'b0, lo(2, 1'b0));
      drain();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/tri_bus_arbiter.md
# tri_bus_arbiter

Sequencing controller for the shared 32-bit three-state data bus. Arbitrates up to N requesters in round-robin order and drives every bufif1-style enable on the bus: requester send/receive enables plus the memory-side endpoint's send/receive enables. Guarantees at most one bus driver per cycle and a forced idle turnaround between ownership or direction changes, so the bus is never contended and never read while floating.

## Interface
- N, 4, number of requesters (2..8)
- MAX_BURST, 8, maximum beats per grant before forced release (1..255)
- TURNAROUND, 1, idle cycles with all enables low between grants (1..3)

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous and active-high
- req  in  N  request per requester; held high until granted burst ends
- wr  in  N  direction per requester: 1 = requester drives bus, 0 = memory endpoint drives bus
- last  in  N  requester marks the current beat as the final one
- gnt  out  N  one-hot grant, registered
- snd_en  out  N  requester i drives bus (gnt[i] & wr[i] in XFER)
- rcv_en  out  N  requester i samples bus (gnt[i] & ~wr[i] in XFER)
- mem_snd_en  out  1  memory endpoint drives bus (read grant active)
- mem_rcv_en  out  1  memory endpoint samples bus (write grant active)
- busy  out  1  high in XFER or TURN
- owner  out  $clog2(N)  index of current grantee; holds last value otherwise

## Operation
- States: IDLE, XFER, TURN. Reset: state IDLE, rr pointer 0, beat count 0, all outputs 0, owner 0.
- IDLE: if any req, pick first set req scanning from pointer upward with wrap (pointer, pointer+1, ..., N-1, 0, ...). Register gnt, owner, direction (wr[k] latched at grant; later wr changes ignored until next grant); enter XFER. Pointer becomes (k+1) mod N.
- XFER: enables asserted per latched direction; exactly one of {snd_en[owner], mem_snd_en} high, its receive counterpart high. Beat count increments each XFER cycle.
- XFER exit (to TURN) on first of: last[owner] sampled high, beat count reaching MAX_BURST, req[owner] sampled low. The beat on which exit is sampled is a valid beat if last or MAX_BURST; req low terminates with that cycle not counted as transfer (enables still high that cycle).
- TURN: all gnt/enables low for exactly TURNAROUND cycles, count reset; then IDLE. Turnaround applies even if the same requester re-wins with same direction.
- Simultaneous requests: round-robin only; no fixed priority except pointer position.
- req from non-owner during XFER/TURN: ignored until IDLE, no loss (req is level).
- rst asserted mid-XFER: all enables drop asynchronously in the same instant; bus floats; pointer returns to 0.

## Timing
- Grant latency: req high sampled at edge t in IDLE -> gnt and enables high after edge t, first beat in cycle t+1.
- Burst of L beats (L ≤ MAX_BURST, last on beat L): enables high for L cycles, then TURNAROUND low cycles, then one IDLE cycle; next grant earliest L+TURNAROUND+1 cycles after first beat.
- Beat count width $clog2(MAX_BURST+1); saturates at MAX_BURST, never wraps.
- All outputs registered; no combinational path from req/wr/last to any enable.
- Invariant every cycle: popcount(snd_en)+mem_snd_en ≤ 1; popcount(gnt) ≤ 1.

## Structure
- Shared package tri_bus_pkg: state encoding constants (IDLE, XFER, TURN), bus width 32, direction constants DIR_WR=1/DIR_RD=0.
- One sub-module: rr_pick — combinational N-bit round-robin picker (req, pointer -> one-hot pick, index, valid). Controller FSM, counters and enable registers stay in tri_bus_arbiter.

## Test plan
- Reset mid-burst: requester 1 writing beat 3, assert rst -> all enables 0 immediately, owner 0, pointer 0; after release req[2] alone granted first.
- Single write: req[0]=1, wr[0]=1, last on beat 3 -> snd_en[0]=mem_rcv_en=1 for 3 cycles, 1 idle cycle, busy low after.
- Round-robin: req=4'b1111 all held, last every beat -> gnt sequence 0,1,2,3,0 with one all-low cycle between each.
- MAX_BURST cut: req[2] read, last never asserted -> rcv_en[2]=mem_snd_en=1 for exactly 8 cycles, then forced TURN, next grant to 3 if requesting else 2 again.
- Direction change same owner: req[1] write burst 2 beats then read burst -> mem_snd_en never rises in the cycle after snd_en[1] falls; driver invariant checked every cycle.
- Early drop: req[3] deasserted on beat 2 with last=0 -> enables low next cycle, TURN entered, pointer = 0.
